// File: rtl/emu_ctrl_pkg.sv
// Shared types and helpers for the emulator run controller.
package emu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } emu_state_e;

    // Width of the reset-cycle counter; never narrower than one bit so that
    // rst_cycles=1 still yields a legal vector.
    function automatic int rst_cnt_width(input int rst_cycles);
        return (rst_cycles > 1) ? $clog2(rst_cycles) : 1;
    endfunction

endpackage

// File: rtl/emu_dec_cnt.sv
// Decimation counter: produces a one-cycle probe strobe every thr+1 active
// cycles. A threshold lowered below the running count wraps before matching.
module emu_dec_cnt #(
    parameter int dec_bits = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [dec_bits-1:0] thr,
    output logic                cmp
);

    logic [dec_bits-1:0] cnt_q;

    assign cmp = en && (cnt_q == thr);

    // Count active cycles, restarting on a match or while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cmp ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/emu_run_ctrl.sv
// Run controller for the emulated design: reset sequencing, free-run and
// N-cycle stepping, plus the probe decimation strobe.
//
//   state | meaning
//   RST   | emulated design held in reset with its clock enabled
//   IDLE  | clock gated off, waiting for run or step request
//   RUN   | free-running clock
//   STEP  | clock enabled for a counted burst
//
// emu_rst, emu_clk_en, busy and done are taken straight from flops, each
// loaded from the next state, so the gating path never sees decode glitches.
module emu_run_ctrl
    import emu_ctrl_pkg::*;
#(
    parameter int dec_bits   = 1,
    parameter int step_bits  = 32,
    parameter int rst_cycles = 4
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic                 rst_req,
    input  logic                 run_cont,
    input  logic                 step_go,
    input  logic [step_bits-1:0] step_cnt,
    input  logic [dec_bits-1:0]  emu_dec_thr,
    output logic                 emu_rst,
    output logic                 emu_clk_en,
    output logic                 emu_dec_cmp,
    output logic                 busy,
    output logic                 done
);

    localparam int             RCW      = rst_cnt_width(rst_cycles);
    localparam logic [RCW-1:0] RST_LAST = RCW'(rst_cycles - 1);

    emu_state_e           state_q, state_d;
    logic [RCW-1:0]       rcnt_q, rcnt_d;
    logic [step_bits-1:0] rem_q, rem_d;
    logic                 step_go_q;
    logic                 emu_rst_q, clk_en_q, busy_q, done_q;
    logic                 step_rise, rst_last;

    assign step_rise = step_go && !step_go_q;
    assign rst_last  = (rcnt_q == RST_LAST);

    // Next-state logic; rst_req overrides everything. The reset counter only
    // advances on enabled cycles so the design sees rst_cycles reset edges.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rem_d   = rem_q;
        if (rst_req) begin
            state_d = ST_RST;
            if (state_q != ST_RST) begin
                rcnt_d = '0;
            end else if (clk_en_q && !rst_last) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_RST: begin
                    if (clk_en_q) begin
                        if (rst_last) begin
                            state_d = run_cont ? ST_RUN : ST_IDLE;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (run_cont) begin
                        state_d = ST_RUN;
                    end else if (step_rise && (step_cnt != '0)) begin
                        rem_d   = step_cnt;
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run_cont) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == step_bits'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_RST;
            endcase
        end
    end

    // State, counters and step_go history.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q   <= ST_RST;
            rcnt_q    <= '0;
            rem_q     <= '0;
            step_go_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            rem_q     <= rem_d;
            step_go_q <= step_go;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            emu_rst_q <= 1'b1;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            emu_rst_q <= (state_d == ST_RST);
            clk_en_q  <= (state_d != ST_IDLE);
            busy_q    <= (state_d == ST_STEP);
            done_q    <= (state_q == ST_STEP) && (state_d == ST_IDLE);
        end
    end

    emu_dec_cnt #(
        .dec_bits (dec_bits)
    ) u_dec_cnt (
        .clk   (emu_clk),
        .rst_n (emu_rst_n),
        .clr   (emu_rst_q),
        .en    (clk_en_q && !emu_rst_q),
        .thr   (emu_dec_thr),
        .cmp   (emu_dec_cmp)
    );

    assign emu_rst    = emu_rst_q;
    assign emu_clk_en = clk_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Self-checking bench for emu_run_ctrl (dec_bits=4, rst_cycles=4).
module tb_emu_run_ctrl;

    localparam int DB = 4;
    localparam int DM = 1 << DB;

    logic          emu_clk = 1'b0;
    logic          emu_rst_n;
    logic          rst_req;
    logic          run_cont;
    logic          step_go;
    logic [31:0]   step_cnt;
    logic [DB-1:0] emu_dec_thr;
    logic          emu_rst, emu_clk_en, emu_dec_cmp, busy, done;

    int checks   = 0;
    int failures = 0;
    int thr_m;     // threshold currently applied
    int nxt;       // active cycles until the next expected strobe
    int strobes;

    always #5 emu_clk = ~emu_clk;

    emu_run_ctrl #(
        .dec_bits   (DB),
        .step_bits  (32),
        .rst_cycles (4)
    ) dut (
        .emu_clk     (emu_clk),
        .emu_rst_n   (emu_rst_n),
        .rst_req     (rst_req),
        .run_cont    (run_cont),
        .step_go     (step_go),
        .step_cnt    (step_cnt),
        .emu_dec_thr (emu_dec_thr),
        .emu_rst     (emu_rst),
        .emu_clk_en  (emu_clk_en),
        .emu_dec_cmp (emu_dec_cmp),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output with the expected cycle.
    task automatic cyc(input logic xen, input logic xrst, input logic xbusy, input logic xdone);
        logic xcmp;
        @(posedge emu_clk);
        #1;
        xcmp = 1'b0;
        if (xrst) begin
            nxt = thr_m;
        end else if (xen) begin
            xcmp = (nxt == 0);
            nxt  = xcmp ? thr_m : nxt - 1;
        end
        chk("emu_rst", emu_rst, xrst);
        chk("emu_clk_en", emu_clk_en, xen);
        chk("busy", busy, xbusy);
        chk("done", done, xdone);
        chk("emu_dec_cmp", emu_dec_cmp, xcmp);
        if (xcmp) strobes++;
    endtask

    // Change threshold; only called after an inactive cycle so the running
    // count is stable. Count = old_thr - nxt; distance wraps modulo 2^DB.
    task automatic set_thr(input int t);
        int c;
        c = thr_m - nxt;
        nxt = (((t - c) % DM) + DM) % DM;
        thr_m = t;
        emu_dec_thr = DB'(t);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst"}, emu_rst, 1'b1);
        chk({tag, "_en"}, emu_clk_en, 1'b0);
        chk({tag, "_cmp"}, emu_dec_cmp, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, m;
        emu_rst_n = 1'b0;
        rst_req = 1'b0;
        run_cont = 1'b0;
        step_go = 1'b0;
        step_cnt = '0;
        emu_dec_thr = DB'(3);
        thr_m = 3;
        nxt = 3;
        strobes = 0;

        // Reset values, then exactly 4 enabled reset cycles into IDLE.
        #12;
        chk_reset_vals("por");
        @(negedge emu_clk);
        emu_rst_n = 1'b1;
        repeat (4) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Single 5-cycle burst.
        step_cnt = 5;
        step_go = 1'b1;
        cyc(1, 0, 1, 0);
        step_go = 1'b0;
        repeat (4) cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // step_go held high: only one burst.
        step_cnt = 3;
        step_go = 1'b1;
        repeat (3) cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0);
        step_go = 1'b0;
        cyc(0, 0, 0, 0);

        // step_cnt = 0 is ignored.
        step_cnt = 0;
        step_go = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        step_go = 1'b0;
        cyc(0, 0, 0, 0);

        // Free run, thr=3: every 4th active cycle strobes.
        set_thr(3);
        strobes = 0;
        run_cont = 1'b1;
        repeat (16) cyc(1, 0, 0, 0);
        run_cont = 1'b0;
        cyc(0, 0, 0, 0);
        chk("strobes_thr3", strobes, 4);

        // rst_req in the 3rd cycle of a 10-step burst.
        step_cnt = 10;
        step_go = 1'b1;
        cyc(1, 0, 1, 0);
        step_go = 1'b0;
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        rst_req = 1'b1;
        cyc(1, 1, 0, 0);
        rst_req = 1'b0;
        repeat (3) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Threshold lowered below the running count wraps first.
        set_thr(7);
        run_cont = 1'b1;
        repeat (5) cyc(1, 0, 0, 0);
        run_cont = 1'b0;
        cyc(0, 0, 0, 0);
        set_thr(2);
        strobes = 0;
        run_cont = 1'b1;
        repeat (16) cyc(1, 0, 0, 0);
        run_cont = 1'b0;
        cyc(0, 0, 0, 0);
        chk("strobes_wrap", strobes, 1);

        // Async reset mid-RUN, then thr=0 strobes every active cycle.
        run_cont = 1'b1;
        repeat (3) cyc(1, 0, 0, 0);
        #2;
        emu_rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        emu_dec_thr = '0;
        thr_m = 0;
        nxt = 0;
        @(posedge emu_clk);
        #1;
        chk_reset_vals("async_hold");
        @(negedge emu_clk);
        emu_rst_n = 1'b1;
        repeat (4) cyc(1, 1, 0, 0);
        strobes = 0;
        repeat (8) cyc(1, 0, 0, 0);
        run_cont = 1'b0;
        cyc(0, 0, 0, 0);
        chk("strobes_thr0", strobes, 8);

        // Randomized bursts and runs with random thresholds.
        for (int i = 0; i < 10; i++) begin
            set_thr(int'($urandom_range(0, DM - 1)));
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(1, 12));
                step_cnt = 32'(n);
                step_go = 1'b1;
                cyc(1, 0, 1, 0);
                step_go = 1'b0;
                repeat (n - 1) cyc(1, 0, 1, 0);
                cyc(0, 0, 0, 1);
            end else begin
                m = int'($urandom_range(1, 20));
                run_cont = 1'b1;
                repeat (m) cyc(1, 0, 0, 0);
                run_cont = 1'b0;
                cyc(0, 0, 0, 0);
            end
            cyc(0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emu_run_ctrl.md
# emu_run_ctrl

Run controller for the emulator's clock-gating and reset path. It sequences the emulated design's reset and free-run or N-cycle single-step execution, and generates the decimation strobe for probe sampling from the `emu_dec_thr` value the VIO provides. It sits between the VIO/control-register outputs and the clock-enable, reset and probe-trigger inputs of the emulated design.

## Interface
- `dec_bits`, default 1: width of the decimation threshold and counter.
- `step_bits`, default 32: width of the step count.
- `rst_cycles`, default 4: number of enabled cycles that `emu_rst` is held; must be at least 1.

Ports:
- `emu_clk`, in, 1: sole clock.
- `emu_rst_n`, in, 1: asynchronous, active-low reset.
- `rst_req`, in, 1: synchronous level request to re-reset the emulated design.
- `run_cont`, in, 1: level; 1 selects free-run.
- `step_go`, in, 1: a rising edge starts a step burst.
- `step_cnt`, in, `step_bits`: number of enabled cycles per step burst.
- `emu_dec_thr`, in, `dec_bits`: decimation threshold.
- `emu_rst`, out, 1: reset to the emulated design (active-high).
- `emu_clk_en`, out, 1: clock enable to the emulated design.
- `emu_dec_cmp`, out, 1: decimation strobe, 1 cycle wide.
- `busy`, out, 1: high in the STEP state.
- `done`, out, 1: 1-cycle pulse when a step burst completes.

## Operation
- States: RST, IDLE, RUN, STEP. `rst_req=1` forces RST from any state and takes priority over all other inputs.
- Values while `emu_rst_n=0`: state RST, rst counter 0, `emu_rst=1`, `emu_clk_en=0`, `emu_dec_cmp=0`, `busy=0`, `done=0`, decimation counter 0, `step_go` history 0.
- RST:
  - Drives `emu_clk_en=1` and `emu_rst=1`, so the emulated design sees reset clock edges.
  - The rst counter increments each cycle.
  - When the counter reaches `rst_cycles-1` and `rst_req=0`, the next state is RUN if `run_cont=1`, otherwise IDLE.
  - If `rst_req` is still 1, the counter saturates and the block stays in RST.
- IDLE: `emu_clk_en=0`.
  - `run_cont=1` moves to RUN.
  - Otherwise, a `step_go` rising edge with `step_cnt!=0` loads `remaining=step_cnt` and moves to STEP.
  - A `step_go` edge with `step_cnt==0` is ignored, with no `done` pulse.
- RUN: `emu_clk_en=1`. `run_cont=0` moves to IDLE.
- STEP:
  - `emu_clk_en=1` and `busy=1`. `remaining` decrements every cycle.
  - When `remaining==1`, the next state is IDLE and `done` pulses in the first IDLE cycle.
  - `step_go` edges and `run_cont` are ignored until the burst ends.
- Rising-edge detection on `step_go` uses a registered previous value.
- Decimation counter:
  - Advances only on cycles with `emu_clk_en=1` and `emu_rst=0`.
  - `emu_dec_cmp = active && (dec_cnt == emu_dec_thr)`; on that cycle the counter returns to 0, otherwise it increments modulo 2^`dec_bits`.
  - The counter is cleared in RST.
  - `thr=0` gives a strobe on every active cycle. A threshold lowered below the current count wraps through 2^`dec_bits` before matching.

## Timing
- `emu_rst`, `emu_clk_en`, `busy` and `done` come directly from flops, with no combinational decode, so they are glitch-free for clock gating.
- `emu_dec_cmp` is combinational from flops and `emu_dec_thr`, which is quasi-static.
- If `step_go` is sampled 1 at edge k after being sampled 0 at edge k-1, then `emu_clk_en` is high for exactly `step_cnt` cycles, starting after edge k.
- `run_cont` 0→1 in IDLE: `emu_clk_en` is high one cycle later. `run_cont` 1→0 in RUN: `emu_clk_en` is low one cycle later.
- After `emu_rst_n` deasserts with `rst_req=0`: exactly `rst_cycles` cycles with `emu_rst=1` and `emu_clk_en=1`.
- `rst_req` asserted mid-STEP: the burst is aborted, there is no `done` pulse, and `emu_rst` is high on the next cycle.

## Structure
- Package `emu_ctrl_pkg`: state enum typedef (RST, IDLE, RUN, STEP) and the width-check function for `rst_cycles`.
- Sub-module `emu_dec_cnt`: the decimation counter and comparator, with ports clk, rst_n, clr, en, thr, cmp.

## Test plan
- Reset release, `rst_cycles=4`, `run_cont=0` → `emu_rst` high for 4 enabled cycles, then IDLE with `emu_clk_en=0`.
- In IDLE, `step_cnt=5` and one `step_go` pulse → `emu_clk_en` high for exactly 5 cycles, then `done` pulses once.
- `run_cont=1` with `emu_dec_thr=3` → `emu_dec_cmp` on every 4th enabled cycle. With `thr=0` → strobe every cycle.
- `step_go` held high across two bursts → only one burst. `step_cnt=0` → nothing happens.
- `rst_req` pulsed in the 3rd cycle of a 10-step burst → burst aborts, 4 reset cycles follow, no `done` pulse.
- `emu_rst_n` asserted mid-RUN → all outputs take their reset values immediately, without waiting for a clock edge.
